// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults, fill-state encoding and its decode helper for seq_det_param
package seq_det_pkg;
    typedef enum logic [1:0] {EMPTY, FILLING, ARMED} fill_state_e;
    localparam int DEF_LEN = 4;
    localparam logic [3:0] DEF_PAT = 4'b1011;
    localparam int DEF_CNT_W = 8;
    function automatic fill_state_e fill_state(input int fill, input int len);
        return fill == 0 ? EMPTY : fill < len ? FILLING : ARMED;
    endfunction
endpackage

// File: rtl/seq_det_param_if.sv
// seq_det_param_if: serial stream, pattern programming and match outputs (pat_mask only with SEQ_DET_MASK_EN)
interface seq_det_param_if #(
    parameter int LEN = seq_det_pkg::DEF_LEN,
    parameter int CNT_W = seq_det_pkg::DEF_CNT_W
);
    logic in_valid;
    logic in_bit;
    logic overlap_en;
    logic pat_load;
    logic [LEN-1:0] pat_in;
`ifdef SEQ_DET_MASK_EN
    logic [LEN-1:0] pat_mask;
`endif
    logic out;
    logic [CNT_W-1:0] match_cnt;
`ifdef SEQ_DET_MASK_EN
    modport master (output in_valid, in_bit, overlap_en, pat_load, pat_in, pat_mask, input out, match_cnt);
    modport slave (input in_valid, in_bit, overlap_en, pat_load, pat_in, pat_mask, output out, match_cnt);
`else
    modport master (output in_valid, in_bit, overlap_en, pat_load, pat_in, input out, match_cnt);
    modport slave (input in_valid, in_bit, overlap_en, pat_load, pat_in, output out, match_cnt);
`endif
endinterface

// File: rtl/seq_det_param_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/seq_det_param.sv
// seq_det_param: programmable LEN-bit serial pattern detector with overlap mode and saturating hit count
// Optional SEQ_DET_MASK_EN adds a per-bit don't-care mask loaded with the pattern.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int LEN = DEF_LEN,
    parameter logic [LEN-1:0] DEFAULT_PAT = LEN'(DEF_PAT),
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk,
    input logic rst,
    seq_det_param_if.slave bus
);
    localparam int FW = $clog2(LEN + 1);
    logic [LEN-1:0] hist_q, hist_d, pat_q, pat_d, care;
    logic [FW-1:0] fill_q, fill_d, fill_inc;
    logic out_q, out_d, accept, match;
`ifdef SEQ_DET_MASK_EN
    logic [LEN-1:0] mask_q, mask_d;
    always_comb begin
        mask_d = bus.pat_load ? bus.pat_mask : mask_q;
        care = ~mask_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mask_q <= '0;
        else mask_q <= mask_d;
    end
`else
    assign care = '1;
`endif
    always_comb begin
        accept = bus.in_valid && !bus.pat_load;
        fill_inc = (fill_q == FW'(LEN)) ? fill_q : fill_q + 1'b1;
        hist_d = accept ? {hist_q[LEN-2:0], bus.in_bit} : hist_q;
        match = accept && fill_inc == FW'(LEN) && ((hist_d ^ pat_q) & care) == '0;
        // Non-overlap restarts the fill count but keeps shifting history
        fill_d = bus.pat_load ? '0 : !accept ? fill_q : (match && !bus.overlap_en) ? '0 : fill_inc;
        pat_d = bus.pat_load ? bus.pat_in : pat_q;
        out_d = match;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q <= DEFAULT_PAT;
            out_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q <= pat_d;
            out_q <= out_d;
        end
    end
    sat_counter #(.W(CNT_W)) u_cnt (.clk(clk), .rst(rst), .inc(match), .cnt(bus.match_cnt));
    assign bus.out = out_q;
    assert property (@(posedge clk) disable iff (rst)
        (match && !bus.overlap_en) |=> fill_state(int'(fill_q), LEN) == EMPTY);
endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: directed vector table plus random stream checked against a queue-based window model
module tb_seq_det_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;

    seq_det_param_if #(.LEN(4), .CNT_W(8)) bus ();
    seq_det_param_if #(.LEN(4), .CNT_W(2)) bus2 ();
    seq_det_param #(.LEN(4), .DEFAULT_PAT(4'b1011), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    seq_det_param #(.LEN(4), .DEFAULT_PAT(4'b1011), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    assign bus2.in_valid = bus.in_valid;
    assign bus2.in_bit = bus.in_bit;
    assign bus2.overlap_en = bus.overlap_en;
    assign bus2.pat_load = bus.pat_load;
    assign bus2.pat_in = bus.pat_in;
`ifdef SEQ_DET_MASK_EN
    assign bus2.pat_mask = bus.pat_mask;
`endif

    // Model: accepted bits since the window was last cleared, newest last
    bit win[$];
    logic [3:0] m_pat, m_mask;
    logic m_out;
    int m_hits;

    function automatic int sat(input int v, input int mx);
        return v > mx ? mx : v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_pat = 4'b1011;
        m_mask = 4'b0000;
        m_out = 1'b0;
        m_hits = 0;
    endtask

    task automatic model_edge(input logic v, b, ov, ld, input logic [3:0] p, m);
        logic [3:0] w;
        m_out = 1'b0;
        if (ld) begin
            m_pat = p;
`ifdef SEQ_DET_MASK_EN
            m_mask = m;
`endif
            win.delete();
        end else if (v) begin
            win.push_back(b);
            if (win.size() > 4) void'(win.pop_front());
            w = '0;
            foreach (win[i]) w = {w[2:0], win[i]};
            if (win.size() == 4 && ((w ^ m_pat) & ~m_mask) == 4'b0000) begin
                m_out = 1'b1;
                m_hits++;
                if (!ov) win.delete();
            end
        end
    endtask

    task automatic step(input logic v, b, ov, ld, input logic [3:0] p, m);
        bus.in_valid = v;
        bus.in_bit = b;
        bus.overlap_en = ov;
        bus.pat_load = ld;
        bus.pat_in = p;
`ifdef SEQ_DET_MASK_EN
        bus.pat_mask = m;
`endif
        @(posedge clk);
        model_edge(v, b, ov, ld, p, m);
        #1;
        chk("out", int'(bus.out), int'(m_out));
        chk("cnt8", int'(bus.match_cnt), sat(m_hits, 255));
        chk("cnt2", int'(bus2.match_cnt), sat(m_hits, 3));
    endtask

    // Called 1 time unit after a rising edge; reset lands between edges
    task automatic do_reset();
        #2 rst = 1'b1;
        #2;
        chk("rst_out", int'(bus.out), 0);
        chk("rst_cnt", int'(bus.match_cnt), 0);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit r;
        bit v, b, ov, ld;
        logic [3:0] p;
        int eo, ec;
    } vec_t;
    vec_t tbl[$];

    initial begin
        model_reset();
        bus.in_valid = 1'b0;
        bus.in_bit = 1'b0;
        bus.overlap_en = 1'b1;
        bus.pat_load = 1'b0;
        bus.pat_in = '0;
`ifdef SEQ_DET_MASK_EN
        bus.pat_mask = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", int'(bus.out), 0);
        chk("rst_cnt", int'(bus.match_cnt), 0);
        rst = 1'b0;

        // Overlap on: 1011011 hits after bits 4 and 7
        tbl.push_back('{1,1,1,1,0,4'h0,0,0}); tbl.push_back('{0,1,0,1,0,4'h0,0,0});
        tbl.push_back('{0,1,1,1,0,4'h0,0,0}); tbl.push_back('{0,1,1,1,0,4'h0,1,1});
        tbl.push_back('{0,1,0,1,0,4'h0,0,1}); tbl.push_back('{0,1,1,1,0,4'h0,0,1});
        tbl.push_back('{0,1,1,1,0,4'h0,1,2});
        // Overlap off: the same stream hits only once
        tbl.push_back('{1,1,1,0,0,4'h0,0,0}); tbl.push_back('{0,1,0,0,0,4'h0,0,0});
        tbl.push_back('{0,1,1,0,0,4'h0,0,0}); tbl.push_back('{0,1,1,0,0,4'h0,1,1});
        tbl.push_back('{0,1,0,0,0,4'h0,0,1}); tbl.push_back('{0,1,1,0,0,4'h0,0,1});
        tbl.push_back('{0,1,1,0,0,4'h0,0,1});
        // Valid gaps between bits 2 and 3
        tbl.push_back('{1,1,1,1,0,4'h0,0,0}); tbl.push_back('{0,1,0,1,0,4'h0,0,0});
        tbl.push_back('{0,0,1,1,0,4'h0,0,0}); tbl.push_back('{0,0,0,1,0,4'h0,0,0});
        tbl.push_back('{0,0,1,1,0,4'h0,0,0}); tbl.push_back('{0,1,1,1,0,4'h0,0,0});
        tbl.push_back('{0,1,1,1,0,4'h0,1,1});
        // Load 0110 with a concurrent sample that must be dropped; old 1011 then misses
        tbl.push_back('{1,1,0,1,1,4'h6,0,0}); tbl.push_back('{0,1,0,1,0,4'h0,0,0});
        tbl.push_back('{0,1,1,1,0,4'h0,0,0}); tbl.push_back('{0,1,1,1,0,4'h0,0,0});
        tbl.push_back('{0,1,0,1,0,4'h0,1,1}); tbl.push_back('{0,1,1,1,0,4'h0,0,1});
        tbl.push_back('{0,1,0,1,0,4'h0,0,1}); tbl.push_back('{0,1,1,1,0,4'h0,0,1});
        tbl.push_back('{0,1,1,1,0,4'h0,0,1});
        foreach (tbl[i]) begin
            if (tbl[i].r) do_reset();
            step(tbl[i].v, tbl[i].b, tbl[i].ov, tbl[i].ld, tbl[i].p, 4'h0);
            chk($sformatf("tbl%0d_out", i), int'(bus.out), tbl[i].eo);
            chk($sformatf("tbl%0d_cnt", i), int'(bus.match_cnt), tbl[i].ec);
        end

        // Two-bit counter saturates at 3 over five overlapping hits
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 1, 0, 4'h0, 4'h0);
            step(1, 0, 1, 0, 4'h0, 4'h0);
            step(1, 1, 1, 0, 4'h0, 4'h0);
            step(1, 1, 1, 0, 4'h0, 4'h0);
            chk("sat_cnt2", int'(bus2.match_cnt), k + 1 > 3 ? 3 : k + 1);
            chk("sat_cnt8", int'(bus.match_cnt), k + 1);
        end

        // Mid-stream reset discards the partial 101
        do_reset();
        step(1, 1, 1, 0, 4'h0, 4'h0);
        step(1, 0, 1, 0, 4'h0, 4'h0);
        step(1, 1, 1, 0, 4'h0, 4'h0);
        do_reset();
        step(1, 1, 1, 0, 4'h0, 4'h0);
        chk("midrst_out", int'(bus.out), 0);
        chk("midrst_cnt", int'(bus.match_cnt), 0);

`ifdef SEQ_DET_MASK_EN
        do_reset();
        step(0, 0, 1, 1, 4'b1011, 4'b0100);
        for (int k = 0; k < 4; k++) step(1, 1, 1, 0, 4'h0, 4'h0);
        chk("mask_out", int'(bus.out), 1);
`endif

        // Random stream against the window model
        do_reset();
        begin
            logic ov = 1'b1;
            logic [3:0] p, m;
            for (int k = 0; k < 600; k++) begin
                if ($urandom_range(0, 19) == 0) ov = ~ov;
                p = 4'($urandom);
                m = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                step($urandom_range(0, 9) < 7, 1'($urandom), ov, $urandom_range(0, 39) == 0, p, m);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised successor to the single-pattern serial sequence detector.
- Detects a runtime-programmable LEN-bit pattern on a serial bit stream qualified by a valid strobe.
- Supports overlapping and non-overlapping detection modes and keeps a saturating hit counter.
- Sits between a serial front-end (deserialiser/sampler) and control logic that consumes a one-cycle match pulse.

Parameters:
- LEN, 4, pattern length in bits (>=2).
- DEFAULT_PAT, 4'b1011, pattern loaded at reset; width LEN.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_bit is sampled on this cycle.
- in_bit  in  1  serial data bit.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- pat_load  in  1  load pat_in into the pattern register.
- pat_in  in  LEN  new pattern; MSB is the first bit received.
- out  out  1  registered one-cycle match pulse.
- match_cnt  out  CNT_W  saturating count of matches since reset.

Behaviour:
- Reset (async, rst=1):
  - hist=0, fill=0, pat=DEFAULT_PAT.
  - out=0, match_cnt=0.
  - Reset mid-stream discards all partial history.
- History:
  - On an accepted sample (in_valid=1, pat_load=0): hist_n = {hist[LEN-2:0], in_bit} and fill_n = min(fill+1, LEN).
  - in_valid=0: hist and fill hold.
- Fill state machine, encoded in fill:
  - EMPTY (fill=0) -> FILLING (0<fill<LEN) -> ARMED (fill=LEN).
  - ARMED holds while samples arrive.
- Match condition: accepted sample AND fill_n==LEN AND hist_n==pat.
- out:
  - out <= match condition, so it is high exactly one cycle after the clock edge that samples the completing bit.
  - Latency: 1 cycle. Back-to-back pulses are possible in overlap mode.
- Non-overlap (overlap_en=0): on a match, fill <= 0 while hist still shifts. The next match needs LEN fresh bits.
- Overlap (overlap_en=1): fill stays at LEN, so any suffix is reusable.
- pat_load=1:
  - pat <= pat_in, fill <= 0, out <= 0.
  - Any simultaneous in_valid sample is discarded.
  - pat_load takes priority over everything except rst.
- match_cnt: increments on each match and saturates at all-ones (no wrap).
- Mode change mid-stream takes effect for the next match evaluation. fill is not cleared.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Adds input port pat_mask[LEN] and a mask register loaded alongside pat on pat_load.
  - Reset value of the mask register is all-zeros.
  - A bit with mask=1 is don't-care: match is ((hist_n ^ pat) & ~mask)==0.
- Undefined: no port and no register; all LEN bits are compared exactly.

Decomposition:
- Package seq_det_pkg holds:
  - typedef fill_state_e {EMPTY, FILLING, ARMED}, used for debug/assertions.
  - Default constants DEF_LEN=4, DEF_PAT=4'b1011, DEF_CNT_W=8.
- One natural sub-module: sat_counter (CNT_W-wide, inc enable, saturating), reusable elsewhere.
- History/pattern compare stays in the top module.

Test Plan:
1. Reset defaults, LEN=4, overlap_en=1: stream 1,0,1,1,0,1,1 with in_valid every cycle -> out pulses after bits 4 and 7; match_cnt=2.
2. Same stream with overlap_en=0 -> single pulse after bit 4; match_cnt=1.
3. Valid gaps: bits 1,0,1,1 with in_valid=0 for 3 cycles between bits 2 and 3 -> exactly one pulse, 1 cycle after bit 4's edge; out stays 0 during the gaps.
4. pat_load with pat_in=4'b0110 asserted together with in_valid, then stream 0,1,1,0 -> the concurrent sample is dropped, one pulse after the 4th post-load bit; the old pattern 1011 no longer matches.
5. CNT_W=2, overlap_en=1, 5 matches (stream 1011 repeated) -> match_cnt sequence 1,2,3,3,3.
6. Reset mid-stream after 1,0,1: assert rst asynchronously between edges, release, then feed 1 -> no pulse; out=0, match_cnt=0. With SEQ_DET_MASK_EN defined, mask=4'b0100 and stream 1,1,1,1 -> pulse.
